// File: rtl/wb_stage_pkg.sv
// Shared types and constants for the writeback stage.
// Falls back to the cpu_define.v values for REG_SIZE and the load funct3 codes when that header is absent.
`ifndef REG_SIZE
`define REG_SIZE 5
`endif
`ifndef LB
`define LB 3'b000
`endif
`ifndef LH
`define LH 3'b001
`endif
`ifndef LW
`define LW 3'b010
`endif
`ifndef LBU
`define LBU 3'b100
`endif
`ifndef LHU
`define LHU 3'b101
`endif

package wb_stage_pkg;

  // Only the valid bit is stored; WAIT is decoded from the held load and mem_rvalid.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_WAIT  = 2'd2
  } wb_state_e;

  localparam logic [2:0] F3_LB  = `LB;
  localparam logic [2:0] F3_LH  = `LH;
  localparam logic [2:0] F3_LW  = `LW;
  localparam logic [2:0] F3_LBU = `LBU;
  localparam logic [2:0] F3_LHU = `LHU;

endpackage

// File: rtl/wb_stage_load_align.sv
// load_align: selects the addressed byte/half of a data-memory word and sign/zero-extends it.
module load_align
  import wb_stage_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = '0;
    case (funct3)
      F3_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      F3_LH:   data = {{16{half_sel[15]}}, half_sel};
      F3_LW:   data = rdata;
      F3_LBU:  data = {24'd0, byte_sel};
      F3_LHU:  data = {16'd0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// wb_stage: single-entry writeback stage driving the register file write port and a retire counter.
// Define WB_BYPASS_EN to compile in the same-cycle write-to-read forwarding port (byp_*).
module wb_stage
  import wb_stage_pkg::*;
#(
  parameter int unsigned CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [`REG_SIZE-1:0]  in_rd,
  input  logic                  in_wen,
  input  logic                  in_is_load,
  input  logic [2:0]            in_funct3,
  input  logic [1:0]            in_addr_lo,
  input  logic [31:0]           in_alu,
  input  logic                  mem_rvalid,
  input  logic [31:0]           mem_rdata,
  output logic                  rf_wen,
  output logic [`REG_SIZE-1:0]  rf_addr,
  output logic [31:0]           rf_wdata,
`ifdef WB_BYPASS_EN
  input  logic [`REG_SIZE-1:0]  byp_addr,
  input  logic [31:0]           byp_rdata,
  output logic [31:0]           byp_data,
`endif
  output logic [CNT_W-1:0]      retire_cnt
);

  logic                 valid_q;
  logic [`REG_SIZE-1:0] rd_q;
  logic                 wen_q;
  logic                 is_load_q;
  logic [2:0]           funct3_q;
  logic [1:0]           lo_q;
  logic [31:0]          alu_q;

  wb_state_e  state;
  logic       stall;
  logic       complete;
  logic       capture;
  logic [31:0] load_data;

  load_align u_load_align (
    .funct3  (funct3_q),
    .addr_lo (lo_q),
    .rdata   (mem_rdata),
    .data    (load_data)
  );

  always_comb begin
    state = ST_EMPTY;
    if (valid_q) state = (is_load_q && !mem_rvalid) ? ST_WAIT : ST_FULL;
  end

  always_comb begin
    stall    = (state == ST_WAIT);
    complete = (state == ST_FULL);
    in_ready = !stall;
    capture  = in_valid && in_ready;
    rf_wen   = complete && wen_q && (rd_q != '0);
    rf_addr  = valid_q ? rd_q : '0;
    rf_wdata = '0;
    if (complete) rf_wdata = is_load_q ? load_data : alu_q;
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    byp_data = byp_rdata;
    if (rf_wen && (rf_addr == byp_addr)) byp_data = rf_wdata;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= 1'b0;
      rd_q       <= '0;
      wen_q      <= 1'b0;
      is_load_q  <= 1'b0;
      funct3_q   <= '0;
      lo_q       <= '0;
      alu_q      <= '0;
      retire_cnt <= '0;
    end else begin
      valid_q <= capture || stall;
      if (capture) begin
        rd_q      <= in_rd;
        wen_q     <= in_wen;
        is_load_q <= in_is_load;
        funct3_q  <= in_funct3;
        lo_q      <= in_addr_lo;
        alu_q     <= in_alu;
      end
      if (complete) retire_cnt <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Scoreboard bench for wb_stage: driver queues expected register writes, monitor checks each rf_wen cycle.
module tb_wb_stage;

  logic                 clk;
  logic                 rst;
  logic                 in_valid;
  logic                 in_ready;
  logic [`REG_SIZE-1:0] in_rd;
  logic                 in_wen;
  logic                 in_is_load;
  logic [2:0]           in_funct3;
  logic [1:0]           in_addr_lo;
  logic [31:0]          in_alu;
  logic                 mem_rvalid;
  logic [31:0]          mem_rdata;
  logic                 rf_wen;
  logic [`REG_SIZE-1:0] rf_addr;
  logic [31:0]          rf_wdata;
  logic [31:0]          retire_cnt;
`ifdef WB_BYPASS_EN
  logic [`REG_SIZE-1:0] byp_addr;
  logic [31:0]          byp_rdata;
  logic [31:0]          byp_data;
`endif

  typedef struct {
    logic [`REG_SIZE-1:0] addr;
    logic [31:0]          data;
  } exp_t;

  exp_t        sb[$];
  int          n_chk  = 0;
  int          n_fail = 0;
  int unsigned exp_cnt = 0;

  wb_stage #(.CNT_W(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_rd      (in_rd),
    .in_wen     (in_wen),
    .in_is_load (in_is_load),
    .in_funct3  (in_funct3),
    .in_addr_lo (in_addr_lo),
    .in_alu     (in_alu),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata),
    .rf_wen     (rf_wen),
    .rf_addr    (rf_addr),
    .rf_wdata   (rf_wdata),
`ifdef WB_BYPASS_EN
    .byp_addr   (byp_addr),
    .byp_rdata  (byp_rdata),
    .byp_data   (byp_data),
`endif
    .retire_cnt (retire_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic expect_wr(input logic [`REG_SIZE-1:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                       input logic [`REG_SIZE-1:0] rd, input logic wen, input logic [31:0] alu,
                       input logic rv, input logic [31:0] rdata);
    in_valid   = 1'b1;
    in_is_load = ld;
    in_funct3  = f3;
    in_addr_lo = lo;
    in_rd      = rd;
    in_wen     = wen;
    in_alu     = alu;
    mem_rvalid = rv;
    mem_rdata  = rdata;
  endtask

  // One isolated instruction: capture, complete one cycle later, counter checked both sides.
  task automatic single(input logic ld, input logic [2:0] f3, input logic [1:0] lo,
                        input logic [`REG_SIZE-1:0] rd, input logic wen, input logic [31:0] alu,
                        input logic rv, input logic [31:0] rdata);
    drive(ld, f3, lo, rd, wen, alu, rv, rdata);
    @(negedge clk); chk("in_ready_empty", in_ready, 1);
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("cnt_before_retire", retire_cnt, exp_cnt);
    step();
    mem_rvalid = 1'b0;
    in_is_load = 1'b0;
    exp_cnt++;
    @(negedge clk); chk("cnt_after_retire", retire_cnt, exp_cnt);
    step();
  endtask

  // Monitor: every write the DUT presents must match the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rf_wen === 1'b1) begin
        if (sb.size() == 0) begin
          chk("unexpected_write_addr", rf_addr, '1);
        end else begin
          e = sb.pop_front();
          chk("wr_addr", rf_addr, e.addr);
          chk("wr_data", rf_wdata, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, required $finish");
    $fatal(1);
  end

  logic [31:0] b2b_data [4];

  initial begin
    b2b_data = '{32'h0000_0100, 32'h0000_0201, 32'h0000_0302, 32'h0000_0403};
    rst = 1'b1;
    in_valid = 0; in_rd = '0; in_wen = 0; in_is_load = 0; in_funct3 = '0;
    in_addr_lo = '0; in_alu = '0; mem_rvalid = 0; mem_rdata = '0;
`ifdef WB_BYPASS_EN
    byp_addr = '0; byp_rdata = '0;
`endif
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rf_wen", rf_wen, 0);
    chk("rst_rf_addr", rf_addr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_retire_cnt", retire_cnt, 0);
    @(posedge clk); #2;
    rst = 1'b0;

    expect_wr(5, 32'h1234_5678);
    single(0, 3'b000, 2'd0, 5, 1, 32'h1234_5678, 0, 32'h0);
    @(negedge clk);
    chk("idle_rf_wen", rf_wen, 0);
    chk("idle_rf_addr", rf_addr, 0);
    chk("idle_rf_wdata", rf_wdata, 0);
    step();

    expect_wr(4, 32'hFFFF_FF80);
    single(1, 3'b000, 2'd2, 4, 1, 32'h0, 1, 32'h0080_0000);
    expect_wr(4, 32'h0000_0080);
    single(1, 3'b100, 2'd2, 4, 1, 32'h0, 1, 32'h0080_0000);
    expect_wr(6, 32'h0000_007F);
    single(1, 3'b000, 2'd0, 6, 1, 32'h0, 1, 32'h1234_567F);
    expect_wr(6, 32'hFFFF_FF81);
    single(1, 3'b000, 2'd3, 6, 1, 32'h0, 1, 32'h8100_0000);
    expect_wr(7, 32'hFFFF_8001);
    single(1, 3'b001, 2'd3, 7, 1, 32'h0, 1, 32'h8001_1234);
    expect_wr(7, 32'h0000_F234);
    single(1, 3'b101, 2'd1, 7, 1, 32'h0, 1, 32'h8001_F234);
    expect_wr(8, 32'hCAFE_BABE);
    single(1, 3'b010, 2'd3, 8, 1, 32'h0, 1, 32'hCAFE_BABE);
    expect_wr(9, 32'h0000_0000);
    single(1, 3'b011, 2'd0, 9, 1, 32'h0, 1, 32'hFFFF_FFFF);
    // Non-load with mem_rvalid high: rdata must not leak into the result.
    expect_wr(10, 32'h0BAD_F00D);
    single(0, 3'b000, 2'd0, 10, 1, 32'h0BAD_F00D, 1, 32'hFFFF_FFFF);

    // x0 and wen=0 retire without writing
    single(0, 3'b000, 2'd0, 0, 1, 32'hFFFF_FFFF, 0, 32'h0);
    single(0, 3'b000, 2'd0, 12, 0, 32'hFFFF_FFFF, 0, 32'h0);

    // Load waits 3 cycles while the next instruction is held off
    expect_wr(3, 32'hFFFF_FF80);
    expect_wr(9, 32'hAAAA_5555);
    drive(1, 3'b000, 2'd2, 3, 1, 32'h0, 0, 32'h0080_0000);
    @(negedge clk); chk("wait_ready_before", in_ready, 1);
    step();
    drive(0, 3'b000, 2'd0, 9, 1, 32'hAAAA_5555, 0, 32'h0080_0000);
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("wait_in_ready", in_ready, 0);
      chk("wait_rf_wen", rf_wen, 0);
      chk("wait_rf_addr", rf_addr, 3);
      chk("wait_rf_wdata", rf_wdata, 0);
      chk("wait_cnt", retire_cnt, exp_cnt);
      step();
    end
    mem_rvalid = 1'b1;
    @(negedge clk); chk("wait_done_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    mem_rvalid = 1'b0;
    @(negedge clk); chk("held_off_accepted", rf_wen, 1);
    step();
    exp_cnt += 2;
    @(negedge clk); chk("wait_cnt_after", retire_cnt, exp_cnt);
    step();

    // Back-to-back non-loads, one per cycle
    for (int unsigned i = 0; i < 4; i++) begin
      expect_wr(`REG_SIZE'(20 + i), b2b_data[i]);
      drive(0, 3'b000, 2'd0, `REG_SIZE'(20 + i), 1, b2b_data[i], 0, 32'h0);
      @(negedge clk); chk("b2b_in_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0;
    step();
    exp_cnt += 4;
    @(negedge clk); chk("b2b_cnt", retire_cnt, exp_cnt);
    step();

`ifdef WB_BYPASS_EN
    expect_wr(7, 32'hDEAD_BEEF);
    drive(0, 3'b000, 2'd0, 7, 1, 32'hDEAD_BEEF, 0, 32'h0);
    byp_addr = 7;
    byp_rdata = 32'h1111_2222;
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("byp_hit", byp_data, 32'hDEAD_BEEF);
    byp_addr = 8;
    #1 chk("byp_miss", byp_data, 32'h1111_2222);
    step();
    exp_cnt++;
`endif

    // Reset while a load waits drops it
    drive(1, 3'b010, 2'd0, 11, 1, 32'h0, 0, 32'h5555_5555);
    step();
    in_valid = 1'b0;
    @(negedge clk); chk("rstwait_stalled", in_ready, 0);
    step();
    rst = 1'b1;
    #1;
    chk("rstwait_rf_wen", rf_wen, 0);
    chk("rstwait_cnt", retire_cnt, 0);
    chk("rstwait_in_ready", in_ready, 1);
    chk("rstwait_rf_addr", rf_addr, 0);
    mem_rvalid = 1'b1;
    step();
    step();
    rst = 1'b0;
    exp_cnt = 0;
    @(negedge clk); chk("post_rst_cnt", retire_cnt, 0);
    step();
    mem_rvalid = 1'b0;

    expect_wr(1, 32'h0000_0042);
    single(0, 3'b000, 2'd0, 1, 1, 32'h0000_0042, 0, 32'h0);

    chk("scoreboard_drained", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
